// File: rtl/counter_rr_arbiter.sv
// rtl/counter_rr_arbiter.sv - round-robin arbiter granting bursts on a shared 8-bit counter
module counter_rr_arbiter #(
    parameter int BURST_W = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [3:0]         req_i,
    input  logic [BURST_W-1:0] burst_len_i,
    input  logic               ov_i,
    output logic [3:0]         gnt_o,
    output logic [1:0]         sel_o,
    output logic               en_o,
    output logic               clr_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [3:0]         ov_flag_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CLEAR   = 2'd1,
        S_RUN     = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t             state_q;
    logic [3:0]         gnt_q;
    logic [1:0]         sel_q;
    logic               en_q;
    logic               clr_q;
    logic               busy_q;
    logic               done_q;
    logic [3:0]         ov_flag_q;
    logic [1:0]         last_owner_q;
    logic [BURST_W:0]   cnt_q;

    logic [1:0]         win_d;
    logic [BURST_W:0]   burst_d;

    // Round-robin pick: first requester above the last owner, wrapping, with the last owner itself last
    always_comb begin
        logic       found;
        logic [1:0] cand;
        win_d = last_owner_q;
        found = 1'b0;
        cand  = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            cand = last_owner_q + 2'(i);
            if (!found && req_i[cand]) begin
                win_d = cand;
                found = 1'b1;
            end
        end
    end

    // A zero burst length stands for the full 2^BURST_W increments
    always_comb begin
        burst_d = {1'b0, burst_len_i};
        if (burst_len_i == '0) begin
            burst_d = {1'b1, {BURST_W{1'b0}}};
        end
    end

    // Grant FSM; every output is a register updated together with the state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            gnt_q        <= 4'b0000;
            sel_q        <= 2'd0;
            en_q         <= 1'b0;
            clr_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ov_flag_q    <= 4'b0000;
            last_owner_q <= 2'd3;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|req_i) begin
                        state_q          <= S_CLEAR;
                        gnt_q            <= 4'b0001 << win_d;
                        sel_q            <= win_d;
                        clr_q            <= 1'b1;
                        busy_q           <= 1'b1;
                        cnt_q            <= burst_d;
                        ov_flag_q[win_d] <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    state_q <= S_RUN;
                    clr_q   <= 1'b0;
                    en_q    <= 1'b1;
                end
                S_RUN: begin
                    if (ov_i) begin
                        ov_flag_q[sel_q] <= 1'b1;
                    end
                    cnt_q <= cnt_q - 1'b1;
                    // Leave after the last latched EN cycle, or early if the owner let go
                    if (!req_i[sel_q] || cnt_q == (BURST_W+1)'(1)) begin
                        state_q <= S_RELEASE;
                        en_q    <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_RELEASE: begin
                    // The cycle right after the last EN still records an overflow
                    if (ov_i) begin
                        ov_flag_q[sel_q] <= 1'b1;
                    end
                    state_q      <= S_IDLE;
                    last_owner_q <= sel_q;
                    gnt_q        <= 4'b0000;
                    sel_q        <= 2'd0;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt_o     = gnt_q;
    assign sel_o     = sel_q;
    assign en_o      = en_q;
    assign clr_o     = clr_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign ov_flag_o = ov_flag_q;

endmodule

// File: tb/tb_counter_rr_arbiter.sv
// tb/tb_counter_rr_arbiter.sv - randomized self-checking bench for counter_rr_arbiter
module tb_counter_rr_arbiter;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [3:0] req_i;
    logic [3:0] burst_len_i;
    logic       ov_i;
    logic [3:0] gnt_o;
    logic [1:0] sel_o;
    logic       en_o;
    logic       clr_o;
    logic       busy_o;
    logic       done_o;
    logic [3:0] ov_flag_o;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state: who was served last and which requesters saw an overflow
    int         m_last;
    logic [3:0] m_ovf;

    counter_rr_arbiter #(.BURST_W(4)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .burst_len_i (burst_len_i),
        .ov_i        (ov_i),
        .gnt_o       (gnt_o),
        .sel_o       (sel_o),
        .en_o        (en_o),
        .clr_o       (clr_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .ov_flag_o   (ov_flag_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] g, input logic [1:0] s,
                              input logic e, input logic c, input logic b, input logic d);
        check_eq({tag, ".gnt"},  32'(gnt_o),     32'(g));
        check_eq({tag, ".sel"},  32'(sel_o),     32'(s));
        check_eq({tag, ".en"},   32'(en_o),      32'(e));
        check_eq({tag, ".clr"},  32'(clr_o),     32'(c));
        check_eq({tag, ".busy"}, 32'(busy_o),    32'(b));
        check_eq({tag, ".done"}, 32'(done_o),    32'(d));
        check_eq({tag, ".ovf"},  32'(ov_flag_o), 32'(m_ovf));
    endtask

    // First requesting index strictly after 'last', wrapping around four slots
    function automatic int rr_pick(input int last, input logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (last + k) % 4;
            if (r[c]) return c;
        end
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        req_i = 4'b0000;
        for (int i = 0; i < n; i++) begin
            ov_i = 1'($urandom);
            tick();
            check_outs("idle", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        ov_i = 1'b0;
    endtask

    // One complete grant: CLEAR, E enable cycles, RELEASE, then the mandatory IDLE cycle.
    // abort_k > 0 drops the owner's request after that EN cycle; rst_k > 0 pulses reset inside it.
    task automatic do_grant(input logic [3:0] r, input logic [3:0] blen, input int abort_k,
                            input int rst_k, input int ov_pct);
        int         w;
        int         len;
        int         n_en;
        logic [3:0] g;
        logic [1:0] s;
        logic       pend;
        w    = rr_pick(m_last, r);
        g    = 4'(1 << w);
        s    = 2'(w);
        len  = (blen == 4'd0) ? 16 : int'(blen);
        n_en = (abort_k > 0) ? abort_k : len;
        req_i       = r;
        burst_len_i = blen;
        ov_i        = 1'($urandom);
        tick();
        m_ovf[w] = 1'b0;
        check_outs("clear", g, s, 1'b0, 1'b1, 1'b1, 1'b0);
        // Disturb everything the current grant must ignore
        burst_len_i = 4'($urandom);
        req_i       = (4'($urandom) & ~g) | g;
        ov_i        = 1'($urandom);
        pend        = 1'b0;
        for (int i = 1; i <= n_en; i++) begin
            tick();
            if (pend) m_ovf[w] = 1'b1;
            check_outs("run", g, s, 1'b1, 1'b0, 1'b1, 1'b0);
            if (rst_k == i) begin
                #3 rst_ni = 1'b0;
                #1;
                m_ovf  = 4'b0000;
                m_last = 3;
                check_outs("rst_async", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
                req_i = 4'b0000;
                ov_i  = 1'b0;
                #2 rst_ni = 1'b1;
                tick();
                check_outs("after_rst", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
                return;
            end
            if (i == abort_k) req_i = req_i & ~g;
            if (i[0]) req_i = (4'($urandom) & ~g) | (req_i & g);
            ov_i = ($urandom % 100) < ov_pct;
            pend = ov_i;
        end
        tick();
        if (pend) m_ovf[w] = 1'b1;
        check_outs("release", g, s, 1'b0, 1'b0, 1'b1, 1'b1);
        ov_i = ($urandom % 100) < ov_pct;
        pend = ov_i;
        tick();
        if (pend) m_ovf[w] = 1'b1;
        m_last = w;
        check_outs("post_idle", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        ov_i = 1'b0;
    endtask

    initial begin
        rst_ni      = 1'b0;
        req_i       = 4'b0000;
        burst_len_i = 4'd0;
        ov_i        = 1'b0;
        m_last      = 3;
        m_ovf       = 4'b0000;
        #12;
        check_outs("reset", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_ni = 1'b1;
        tick();
        check_outs("idle0", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Round robin from reset: 0,1,2,3,0 back to back
        for (int i = 0; i < 5; i++) begin
            do_grant(4'b1111, 4'd1, 0, 0, 0);
            check_eq("rr_order", 32'(m_last), 32'(i % 4));
        end
        idle_cycles(2);

        // Single requester, three increments
        do_grant(4'b0001, 4'd3, 0, 0, 0);
        // Zero burst length means sixteen increments
        do_grant(4'b0001, 4'd0, 0, 0, 0);
        // Owner drops its request after the second EN
        do_grant(4'b0010, 4'd8, 2, 0, 0);
        // Overflow recorded for requester 2, then cleared when it is granted again
        do_grant(4'b0100, 4'd4, 0, 0, 100);
        check_eq("ovf_set", 32'(ov_flag_o), 32'h4);
        do_grant(4'b0100, 4'd2, 0, 0, 0);
        idle_cycles(1);

        // Reset during the second EN cycle; requester 0 must then win
        do_grant(4'b0010, 4'd8, 0, 2, 0);
        do_grant(4'b1111, 4'd1, 0, 0, 0);
        check_eq("post_rst_winner", 32'(m_last), 32'd0);

        // Randomized grants
        for (int n = 0; n < 60; n++) begin
            logic [3:0] r;
            logic [3:0] bl;
            int         len;
            int         ab;
            r   = 4'($urandom_range(1, 15));
            bl  = 4'($urandom);
            len = (bl == 4'd0) ? 16 : int'(bl);
            ab  = (len > 1 && ($urandom % 4) == 0) ? int'($urandom_range(1, len - 1)) : 0;
            do_grant(r, bl, ab, 0, 20);
            if (($urandom % 3) == 0) idle_cycles(int'($urandom_range(1, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/counter_rr_arbiter.md
COUNTER_RR_ARBITER -- requirements
Module: counter_rr_arbiter

Interface
REQ-001 Parameter: BURST_W, default 4, width of burst_len; maximum burst is 2^BURST_W increments.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset; Reset=0 forces reset state immediately, independent of clk.
REQ-004 req  input  4  per-requester request for exclusive use of the shared 8-bit counter; level, held until done.
REQ-005 burst_len  input  BURST_W  number of EN cycles requested; sampled only in ARB; value 0 means 2^BURST_W.
REQ-006 OV  input  1  overflow flag from the shared counter.
REQ-007 gnt  output  4  one-hot grant; all-zero when no owner.
REQ-008 sel  output  2  binary index of current owner, drives the downstream case-mux select.
REQ-009 EN  output  1  increment enable to the shared counter.
REQ-010 CLR  output  1  clear command to the shared counter.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse at end of each grant.
REQ-013 ov_flag  output  4  sticky per-requester overflow record.

Function
REQ-014 FSM states SHALL be IDLE, CLEAR, RUN, RELEASE; all outputs registered.
REQ-015 IDLE: if req != 0, winner = first requester with req=1 searching upward (mod 4) from last_owner+1; next state CLEAR; latch burst_len into a down-counter (0 -> 2^BURST_W); else stay IDLE.
REQ-016 CLEAR: exactly one cycle; CLR=1, EN=0, gnt/sel = winner, ov_flag[winner] cleared to 0; next state RUN.
REQ-017 RUN: EN=1, CLR=0 each cycle; down-counter decrements per EN cycle; after the latched number of EN cycles, next state RELEASE.
REQ-018 RUN abort: if req[owner] drops to 0 during RUN, EN=0 from the next cycle and next state RELEASE; EN cycles already issued are not retracted.
REQ-019 RELEASE: one cycle; done=1, EN=0, CLR=0, gnt held; last_owner <= owner; next state IDLE; gnt=0 in IDLE.
REQ-020 Grant latency: req asserted in IDLE at edge N -> CLR and gnt at edge N+1 -> first EN at edge N+2.
REQ-021 Minimum gap between consecutive grants: one IDLE cycle after RELEASE; back-to-back requesters are served with no additional idle cycles.
REQ-022 OV=1 while in RUN or on the cycle immediately after the last EN SHALL set ov_flag[owner]; OV in any other state is ignored.
REQ-023 Simultaneous requests: round-robin order only; no requester is granted twice while another with req=1 waits.
REQ-024 Changes of req for non-owners during CLEAR/RUN/RELEASE are ignored until the next IDLE evaluation.
REQ-025 burst_len changes after ARB sampling SHALL NOT affect the current grant.
REQ-026 gnt is always one-hot or zero; sel equals the gnt index whenever gnt != 0, and 0 when gnt = 0.

Reset
REQ-027 Reset=0: state IDLE, gnt=0, sel=0, EN=0, CLR=0, busy=0, done=0, ov_flag=0, last_owner=3 (so requester 0 has first priority), down-counter=0.
REQ-028 Reset asserted mid-grant SHALL abort immediately with outputs as REQ-027; no done pulse is issued.
REQ-029 The first IDLE evaluation occurs at the first rising clk edge after Reset deasserts.

Verification
REQ-030 Single requester: req=4'b0001, burst_len=3 -> gnt=0001, 1 CLR cycle, exactly 3 EN cycles, done pulse, counter reads 3.
REQ-031 Round robin: req=4'b1111 held, burst_len=1 -> grant order 0,1,2,3,0; sel follows 0,1,2,3,0; each grant lasts 4 cycles.
REQ-032 burst_len=0, BURST_W=4 -> 16 EN cycles; burst_len=0 with 256-cycle depth check not needed; the counter reads 16 after done.
REQ-033 Abort: req=0010, burst_len=8, drop req[1] after 2nd EN -> EN stops, RELEASE, done, counter reads 2 or 3 according to REQ-018 timing.
REQ-034 Overflow: preload the counter to 8'hFE via prior grants, grant requester 2 with burst_len=4 -> OV seen, ov_flag=0100; next grant to requester 2 clears the bit in CLEAR.
REQ-035 Reset mid-RUN: assert Reset=0 during the 2nd EN cycle -> all outputs 0 asynchronously, no done, and requester 0 wins the next grant.
